// File: rtl/arf104b256e1r1w0cbbehcaa4acw_pkg.sv
// Shared constants for the 104b x 256-entry register-file read controller.
// Latency: n/a (package). Backpressure: n/a.
// Holds data/address widths, entry count, response FIFO depth and a mod-3 pointer helper.
package arf104b256e1r1w0cbbehcaa4acw_pkg;

  localparam int DWIDTH         = 104;
  localparam int AWIDTH         = 8;
  localparam int NUM_ENTRIES    = 256;
  localparam int RSP_FIFO_DEPTH = 3;
  localparam int CNT_W          = 2;   // enough for 0..RSP_FIFO_DEPTH

  // Pointer increment that wraps at the (non power-of-two) FIFO depth.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] ptr);
    return (ptr == CNT_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_rd_rsp_fifo.sv
// Purpose: 3-entry in-order response FIFO, pointers wrap modulo 3, no bypass.
// Latency: pushed data visible at o_head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller keeps credits.
// Ports: clk, rst (sync active-low), i_push/i_push_dat, i_pop, o_head_dat, o_count.
module arf104b256e1r1w0cbbehcaa4acw_rd_rsp_fifo
  import arf104b256e1r1w0cbbehcaa4acw_pkg::*;
#(
  parameter int W = arf104b256e1r1w0cbbehcaa4acw_pkg::DWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_head_dat,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [RSP_FIFO_DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push  = i_push & (r_count != CNT_W'(RSP_FIFO_DEPTH));
  assign w_do_pop   = i_pop & (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      // Simultaneous push and pop leaves the count unchanged.
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_rd_ctrl.sv
// Purpose: read controller for a 104b x 256 array; write-first collision forwarding.
// Latency: accept in N -> array data in N+1 -> response visible in N+2.
// Backpressure: credit-based; rd_req_rdy only from registered count+inflight < 3.
// Ports: clk, rst (sync active-low); rd_req_*; wr_* (monitored); arr_rd_*; rd_rsp_*.
module arf104b256e1r1w0cbbehcaa4acw_rd_ctrl
  import arf104b256e1r1w0cbbehcaa4acw_pkg::*;
#(
  parameter int DWIDTH = arf104b256e1r1w0cbbehcaa4acw_pkg::DWIDTH,
  parameter int AWIDTH = arf104b256e1r1w0cbbehcaa4acw_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [AWIDTH-1:0] rd_req_adr,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_adr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              arr_rd_en,
  output logic [AWIDTH-1:0] arr_rd_adr,
  input  logic [DWIDTH-1:0] arr_rd_data,
  output logic              rd_rsp_vld,
  input  logic              rd_rsp_rdy,
  output logic [DWIDTH-1:0] rd_rsp_data
);

  logic              r_inflight;
  logic              r_coll;
  logic [DWIDTH-1:0] r_coll_data;
  logic [CNT_W-1:0]  w_count;
  logic [DWIDTH-1:0] w_head;
  logic [DWIDTH-1:0] w_push_data;
  logic              w_accept;
  logic              w_pop;
  logic              w_credit_ok;

  // Inflight read already owns a FIFO slot, so it counts against credit.
  assign w_credit_ok = ({1'b0, w_count} + {2'b00, r_inflight}) < 3'(RSP_FIFO_DEPTH);
  // rst gating forces outputs idle during the reset cycle itself.
  assign rd_req_rdy  = rst & w_credit_ok;
  assign w_accept    = rd_req_vld & rd_req_rdy;
  assign arr_rd_en   = w_accept;
  assign arr_rd_adr  = rd_req_adr;

  assign rd_rsp_vld  = rst & (w_count != '0);
  assign rd_rsp_data = rd_rsp_vld ? w_head : '0;
  assign w_pop       = rd_rsp_vld & rd_rsp_rdy;

  // A write to the same entry in the accept cycle wins over the array's old data.
  assign w_push_data = r_coll ? r_coll_data : arr_rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight  <= 1'b0;
      r_coll      <= 1'b0;
      r_coll_data <= '0;
    end else begin
      r_inflight <= w_accept;
      r_coll     <= w_accept & wr_en & (wr_adr == rd_req_adr);
      if (w_accept) r_coll_data <= wr_data;
    end
  end

  arf104b256e1r1w0cbbehcaa4acw_rd_rsp_fifo #(
    .W (DWIDTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_inflight),
    .i_push_dat (w_push_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_arf104b256e1r1w0cbbehcaa4acw_rd_ctrl.sv
// Bench for the register-file read controller: scoreboard of expected responses
// filled on every accept and drained on every response handshake.
module tb_arf104b256e1r1w0cbbehcaa4acw_rd_ctrl;

  localparam int DW = 104;
  localparam int AW = 8;
  localparam logic [DW-1:0] JUNK = {13{8'h5A}};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_req_vld = 1'b0;
  logic          rd_req_rdy;
  logic [AW-1:0] rd_req_adr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          arr_rd_en;
  logic [AW-1:0] arr_rd_adr;
  logic [DW-1:0] arr_rd_data = '0;
  logic          rd_rsp_vld;
  logic          rd_rsp_rdy = 1'b0;
  logic [DW-1:0] rd_rsp_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  // Values captured each cycle at the negative edge.
  bit            s_rdy, s_acc, s_en, s_vld, s_rsp;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_d;
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  arf104b256e1r1w0cbbehcaa4acw_rd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req_vld  (rd_req_vld),
    .rd_req_rdy  (rd_req_rdy),
    .rd_req_adr  (rd_req_adr),
    .wr_en       (wr_en),
    .wr_adr      (wr_adr),
    .wr_data     (wr_data),
    .arr_rd_en   (arr_rd_en),
    .arr_rd_adr  (arr_rd_adr),
    .arr_rd_data (arr_rd_data),
    .rd_rsp_vld  (rd_rsp_vld),
    .rd_rsp_rdy  (rd_rsp_rdy),
    .rd_rsp_data (rd_rsp_data)
  );

  // Array contents as seen by reads (writes are not applied: array is read-before-write).
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    if (a == 8'h05) return 104'hA5;
    return {48'hBEEF_0000_CAFE, 48'h0, a};
  endfunction

  // Array model: data one cycle after the read enable, junk otherwise.
  always @(posedge clk) arr_rd_data <= arr_rd_en ? data_of(arr_rd_adr) : JUNK;

  // Advance one cycle: sample at negedge, record accepts in the scoreboard.
  task automatic tick();
    @(negedge clk);
    s_rdy = rd_req_rdy;
    s_acc = rd_req_vld & rd_req_rdy;
    s_en  = arr_rd_en;
    s_adr = arr_rd_adr;
    s_vld = rd_rsp_vld;
    s_rsp = rd_rsp_vld & rd_rsp_rdy;
    s_d   = rd_rsp_data;
    if (s_acc) sb.push_back((wr_en && wr_adr == rd_req_adr) ? wr_data : data_of(rd_req_adr));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_req_vld = 1'b1; rd_req_adr = 8'h05; rd_rsp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rd_req_rdy); end
    checks++; if (arr_rd_en !== 1'b0) begin errors++; $display("FAIL reset_arr_en got %b want 0", arr_rd_en); end
    checks++; if (rd_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %b want 0", rd_rsp_vld); end
    checks++; if (rd_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rd_rsp_data); end
    @(posedge clk); #1;
    rst = 1'b1; rd_req_vld = 1'b0;
    @(negedge clk);
    checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy got %b want 1", rd_req_rdy); end
    checks++; if (rd_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_release_vld got %b want 0", rd_rsp_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rd_req_vld = 1'b1; rd_req_adr = 8'h05; rd_rsp_rdy = 1'b1;
    tick();
    checks++; if (s_en !== 1'b1 || s_adr !== 8'h05) begin errors++; $display("FAIL single_arr_rd got en=%b adr=%h want en=1 adr=05", s_en, s_adr); end
    rd_req_vld = 1'b0;
    tick();
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL single_lat1 got vld=%b want 0", s_vld); end
    tick();
    checks++; if (s_vld !== 1'b1 || s_d !== 104'hA5) begin errors++; $display("FAIL single_rsp got vld=%b data=%h want vld=1 data=a5", s_vld, s_d); end
    if (s_rsp) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL single_sb got response want none"); end
      else begin exp_d = sb.pop_front(); if (s_d !== exp_d) begin errors++; $display("FAIL single_sb got %h want %h", s_d, exp_d); end end
    end
    tick();
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL single_drain got vld=%b want 0", s_vld); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_rsp = 0;
    rd_rsp_rdy = 1'b0; rd_req_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_req_adr = 8'(8'h20 + n_acc);
      tick();
      if (s_acc) n_acc++;
      if (s_vld && sb.size() != 0) begin
        checks++;
        if (s_d !== sb[0]) begin errors++; $display("FAIL bp_stall_data got %h want %h", s_d, sb[0]); end
      end
    end
    checks++; if (n_acc != 3) begin errors++; $display("FAIL bp_accepts got %0d want 3", n_acc); end
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_low got %b want 0", s_rdy); end
    rd_req_vld = 1'b0; rd_rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_rsp) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_sb got extra response %h want none", s_d); end
        else begin exp_d = sb.pop_front(); if (s_d !== exp_d) begin errors++; $display("FAIL bp_order got %h want %h", s_d, exp_d); end end
      end
    end
    checks++; if (n_rsp != 3) begin errors++; $display("FAIL bp_responses got %0d want 3", n_rsp); end
    checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_again got %b want 1", rd_req_rdy); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stalls = 0;
    int first = -1;
    int last = -1;
    rd_rsp_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rd_req_vld = (sent < 20);
      rd_req_adr = 8'(sent);
      tick();
      if (s_acc) sent++;
      else if (rd_req_vld) stalls++;
      if (s_rsp) begin
        if (first < 0) first = c;
        last = c;
        got++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_sb got extra response %h want none", s_d); end
        else begin exp_d = sb.pop_front(); if (s_d !== exp_d) begin errors++; $display("FAIL stream_order got %h want %h", s_d, exp_d); end end
      end
    end
    rd_req_vld = 1'b0;
    checks++; if (stalls != 0 || sent != 20) begin errors++; $display("FAIL stream_accepts got sent=%0d stalls=%0d want 20/0", sent, stalls); end
    checks++; if (got != 20) begin errors++; $display("FAIL stream_count got %0d want 20", got); end
    checks++; if (last - first != 19) begin errors++; $display("FAIL stream_bubbles got span %0d want 19", last - first); end
  endtask

  task automatic test_collision();
    int n_rsp = 0;
    rd_rsp_rdy = 1'b1;
    // Same address written in the accept cycle; a later write must not leak in.
    rd_req_vld = 1'b1; rd_req_adr = 8'h10; wr_en = 1'b1; wr_adr = 8'h10; wr_data = 104'h123;
    tick();
    rd_req_vld = 1'b0; wr_data = 104'h999;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rsp) begin
        n_rsp++;
        checks++; if (s_d !== 104'h123) begin errors++; $display("FAIL coll_hit got %h want 123", s_d); end
        if (sb.size() != 0) exp_d = sb.pop_front();
      end
    end
    checks++; if (n_rsp != 1) begin errors++; $display("FAIL coll_hit_count got %0d want 1", n_rsp); end
    // Write to the entry a cycle early, then a different address in the accept cycle.
    n_rsp = 0;
    wr_en = 1'b1; wr_adr = 8'h10; wr_data = 104'h777;
    tick();
    rd_req_vld = 1'b1; rd_req_adr = 8'h10; wr_adr = 8'h11; wr_data = 104'h456;
    tick();
    rd_req_vld = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rsp) begin
        n_rsp++;
        exp_d = data_of(8'h10);
        checks++; if (s_d !== exp_d) begin errors++; $display("FAIL coll_miss got %h want %h", s_d, exp_d); end
        if (sb.size() != 0) exp_d = sb.pop_front();
      end
    end
    checks++; if (n_rsp != 1) begin errors++; $display("FAIL coll_miss_count got %0d want 1", n_rsp); end
  endtask

  task automatic test_reset_midstream();
    int n_acc = 0;
    int stale = 0;
    int n_rsp = 0;
    rd_rsp_rdy = 1'b0; rd_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req_adr = 8'(8'h30 + i);
      tick();
      if (s_acc) n_acc++;
    end
    checks++; if (n_acc != 3) begin errors++; $display("FAIL rstm_fill got %0d want 3", n_acc); end
    rst = 1'b0; rd_req_vld = 1'b0;
    tick();
    checks++; if (s_vld !== 1'b0 || s_rdy !== 1'b0) begin errors++; $display("FAIL rstm_during got vld=%b rdy=%b want 0/0", s_vld, s_rdy); end
    sb.delete();
    rst = 1'b1; rd_rsp_rdy = 1'b1;
    tick();
    checks++; if (s_vld !== 1'b0 || s_rdy !== 1'b1) begin errors++; $display("FAIL rstm_after got vld=%b rdy=%b want 0/1", s_vld, s_rdy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_vld) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstm_stale got %0d responses want 0", stale); end
    rd_req_vld = 1'b1; rd_req_adr = 8'h07;
    tick();
    rd_req_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rsp) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rstm_sb got extra response %h want none", s_d); end
        else begin exp_d = sb.pop_front(); if (s_d !== exp_d) begin errors++; $display("FAIL rstm_post got %h want %h", s_d, exp_d); end end
      end
    end
    checks++; if (n_rsp != 1) begin errors++; $display("FAIL rstm_post_count got %0d want 1", n_rsp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_collision();
    test_reset_midstream();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
